// File: rtl/run_pkg.sv
// Shared widths, state encodings and arithmetic helpers for the run controller.
// Everything sized here is consumed by run_controller and cycle_counter.
package run_pkg;

    localparam int LAST_W          = 16;
    localparam int TOTAL_W         = 20;
    localparam int RUNS_W          = 4;
    localparam int HOLD_W          = 4;
    localparam int TIMEOUT_DEFAULT = 4096;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_PRST   = 3'd1;
    localparam state_t ST_ASSERT = 3'd2;
    localparam state_t ST_RUN    = 3'd3;
    localparam state_t ST_FIN    = 3'd4;

    // Batch accumulator add that pins at all-ones instead of wrapping.
    function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] acc,
                                                   input logic [LAST_W-1:0]  inc);
        logic [TOTAL_W:0] sum;
        sum = {1'b0, acc} + {{(TOTAL_W - LAST_W + 1){1'b0}}, inc};
        return sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Per-run RUN-cycle counter: saturating up-count with a terminal compare
// against the configured limit.
module cycle_counter
    import run_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    output logic [LAST_W-1:0] count,
    output logic              hit_limit
);

    localparam logic [LAST_W-1:0] LIMIT_VAL = LAST_W'(LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {LAST_W{1'b1}})) begin
            count <= count + LAST_W'(1);
        end
    end

    assign hit_limit = (count == LIMIT_VAL);

endmodule

// File: rtl/run_controller.sv
// Sequences a batch of processor runs: reset pulse, start hold, wait for ack
// or timeout, and accumulates per-run cycle statistics.
//
// state  | meaning
// IDLE   | waiting for launch; results of the last batch held
// PRST   | one-cycle proc_reset pulse ahead of every run
// ASSERT | start held high for START_HOLD cycles
// RUN    | counting cycles until ack or TIMEOUT
// FIN    | one-cycle done pulse, then back to IDLE
module run_controller
    import run_pkg::*;
#(
    parameter int START_HOLD = 2,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               launch,
    input  logic [RUNS_W-1:0]  num_runs,
    output logic               proc_reset,
    output logic               start,
    input  logic               ack,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic [LAST_W-1:0]  last_cycles,
    output logic [TOTAL_W-1:0] total_cycles,
    output logic [RUNS_W-1:0]  runs_done
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
    localparam logic [LAST_W-1:0] LIMIT_VAL = LAST_W'(TIMEOUT);

    state_t              state;
    state_t              state_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [RUNS_W-1:0]   runs_target;
    logic [LAST_W-1:0]   run_count;
    logic                hit_limit;
    logic                run_more;
    logic                cnt_clear;
    logic                cnt_enable;

    assign run_more = ({1'b0, runs_done} + 5'd1) < {1'b0, runs_target};

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (launch) state_next = ST_PRST;
            ST_PRST:   state_next = ST_ASSERT;
            ST_ASSERT: if (hold_cnt == '0) state_next = ST_RUN;
            ST_RUN: begin
                // ack takes priority over the limit compare in the same cycle
                if (ack)            state_next = run_more ? ST_PRST : ST_FIN;
                else if (hit_limit) state_next = ST_FIN;
            end
            ST_FIN:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Counter reads 1 on the first RUN cycle: it steps on the final ASSERT cycle.
    assign cnt_clear  = (state == ST_PRST);
    assign cnt_enable = ((state == ST_ASSERT) && (hold_cnt == '0)) ||
                        ((state == ST_RUN) && (state_next == ST_RUN));

    cycle_counter #(
        .LIMIT (TIMEOUT)
    ) u_cycle_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear),
        .enable    (cnt_enable),
        .count     (run_count),
        .hit_limit (hit_limit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            runs_target  <= '0;
            proc_reset   <= 1'b0;
            start        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timed_out    <= 1'b0;
            last_cycles  <= '0;
            total_cycles <= '0;
            runs_done    <= '0;
        end else begin
            state      <= state_next;
            proc_reset <= (state_next == ST_PRST);
            start      <= (state_next == ST_ASSERT);
            busy       <= (state_next != ST_IDLE);
            done       <= (state_next == ST_FIN);

            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        runs_target  <= (num_runs == '0) ? RUNS_W'(1) : num_runs;
                        runs_done    <= '0;
                        total_cycles <= '0;
                        timed_out    <= 1'b0;
                    end
                end
                ST_PRST: begin
                    hold_cnt <= HOLD_LAST;
                end
                ST_ASSERT: begin
                    if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                ST_RUN: begin
                    if (ack) begin
                        last_cycles  <= run_count;
                        total_cycles <= sat_add(total_cycles, run_count);
                        runs_done    <= runs_done + RUNS_W'(1);
                    end else if (hit_limit) begin
                        timed_out   <= 1'b1;
                        last_cycles <= LIMIT_VAL;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller with START_HOLD=2, TIMEOUT=16; expected
// values are hand-computed per scenario.
module tb_run_controller;
    import run_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               launch;
    logic [RUNS_W-1:0]  num_runs;
    logic               proc_reset;
    logic               start;
    logic               ack;
    logic               busy;
    logic               done;
    logic               timed_out;
    logic [LAST_W-1:0]  last_cycles;
    logic [TOTAL_W-1:0] total_cycles;
    logic [RUNS_W-1:0]  runs_done;

    int checks = 0;
    int errors = 0;
    int pr_total = 0;
    int st_total = 0;
    int done_total = 0;
    int pr0, st0, dn0;

    always #5 clk = ~clk;

    run_controller #(
        .START_HOLD (2),
        .TIMEOUT    (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .launch       (launch),
        .num_runs     (num_runs),
        .proc_reset   (proc_reset),
        .start        (start),
        .ack          (ack),
        .busy         (busy),
        .done         (done),
        .timed_out    (timed_out),
        .last_cycles  (last_cycles),
        .total_cycles (total_cycles),
        .runs_done    (runs_done)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (proc_reset) pr_total   <= pr_total + 1;
            if (start)      st_total   <= st_total + 1;
            if (done)       done_total <= done_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        pr0 = pr_total;
        st0 = st_total;
        dn0 = done_total;
    endtask

    task automatic launch_batch(input logic [RUNS_W-1:0] n);
        num_runs = n;
        launch   = 1'b1;
        tick();
        launch   = 1'b0;
        check("prst_after_launch", 32'(proc_reset), 32'd1);
    endtask

    // Returns in the first RUN cycle; ack follows hold_ack during ASSERT.
    task automatic wait_run_start(input bit hold_ack);
        int n;
        n = 0;
        while (!start && n < 20) begin
            tick();
            n++;
        end
        check("start_rise", 32'(start), 32'd1);
        ack = hold_ack;
        n = 0;
        while (start && n < 20) begin
            tick();
            n++;
        end
        check("start_len", 32'(n), 32'd2);
        ack = 1'b0;
    endtask

    // ack raised on RUN cycle k, left high until the next run's ASSERT.
    task automatic run_one(input int k, input bit hold_ack, input bit relaunch);
        wait_run_start(hold_ack);
        for (int i = 1; i < k; i++) begin
            tick();
            launch = relaunch && (i == 1);
        end
        launch = 1'b0;
        ack = 1'b1;
        tick();
    endtask

    task automatic finish_batch();
        tick();
        ack = 1'b0;
        tick();
    endtask

    task automatic check_batch(input string t, input int last, input int total, input int runs,
                               input int to, input int prs);
        check({t, "_last"},  32'(last_cycles),  32'(last));
        check({t, "_total"}, 32'(total_cycles), 32'(total));
        check({t, "_runs"},  32'(runs_done),    32'(runs));
        check({t, "_tmo"},   32'(timed_out),    32'(to));
        check({t, "_busy"},  32'(busy),         32'd0);
        check({t, "_prst"},  32'(pr_total - pr0),   32'(prs));
        check({t, "_done"},  32'(done_total - dn0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b1;
        launch   = 1'b0;
        ack      = 1'b0;
        num_runs = '0;
        #2;
        check("rst_ctrl",  32'({busy, done, start, proc_reset, timed_out}), 32'd0);
        check("rst_last",  32'(last_cycles),  32'd0);
        check("rst_total", 32'(total_cycles), 32'd0);
        check("rst_runs",  32'(runs_done),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // single run, ack on RUN cycle 5
        snap();
        launch_batch(4'd1);
        run_one(5, 1'b0, 1'b0);
        finish_batch();
        check_batch("one", 5, 5, 1, 0, 1);
        check("one_start_cycles", 32'(st_total - st0), 32'd2);

        // three runs, acks at 4, 7, 10
        snap();
        launch_batch(4'd3);
        run_one(4, 1'b0, 1'b0);
        run_one(7, 1'b0, 1'b0);
        run_one(10, 1'b0, 1'b0);
        finish_batch();
        check_batch("three", 10, 21, 3, 0, 3);
        check("three_start_cycles", 32'(st_total - st0), 32'd6);

        // num_runs of 0 behaves as one run
        snap();
        launch_batch(4'd0);
        run_one(3, 1'b0, 1'b0);
        finish_batch();
        check_batch("zero", 3, 3, 1, 0, 1);

        // ack never arrives: abort after 16 RUN cycles
        snap();
        launch_batch(4'd1);
        wait_run_start(1'b0);
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("tmo_len", 32'(n), 32'd17);
        tick();
        check_batch("tmo", 16, 0, 0, 1, 1);

        // ack on the limit cycle wins
        snap();
        launch_batch(4'd1);
        run_one(16, 1'b0, 1'b0);
        finish_batch();
        check_batch("ack_lim", 16, 16, 1, 0, 1);

        // relaunch during RUN and ack during ASSERT are ignored
        snap();
        launch_batch(4'd1);
        run_one(5, 1'b1, 1'b1);
        finish_batch();
        check_batch("ignore", 5, 5, 1, 0, 1);

        // reset on RUN cycle 3
        snap();
        launch_batch(4'd1);
        wait_run_start(1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_ctrl",  32'({busy, done, start, proc_reset, timed_out}), 32'd0);
        check("mid_rst_last",  32'(last_cycles),  32'd0);
        check("mid_rst_total", 32'(total_cycles), 32'd0);
        check("mid_rst_runs",  32'(runs_done),    32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("mid_rst_no_done", 32'(done_total - dn0), 32'd0);
        check("mid_rst_idle",    32'(busy), 32'd0);

        snap();
        launch_batch(4'd1);
        run_one(5, 1'b0, 1'b0);
        finish_batch();
        check_batch("after_rst", 5, 5, 1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
